// File: rtl/rv32_div_unit_pkg.sv
// Shared types and constants for the RV32M iterative divider.
// Operation encoding, register tag type, divider FSM states and the
// architectural divide-by-zero quotient.
package rv32_div_unit_pkg;

  typedef enum logic [1:0] {
    divop_div  = 2'd0,
    divop_divu = 2'd1,
    divop_rem  = 2'd2,
    divop_remu = 2'd3
  } rv32_divop;

  typedef logic [4:0] rv32_register;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } rv32_div_state;

  // Quotient returned by DIV/DIVU when the divisor is zero.
  localparam logic [31:0] RV32_DIV_ZERO_QUOT = 32'hFFFF_FFFF;

  // DIV and REM interpret their operands as two's-complement values.
  function automatic logic divop_is_signed(rv32_divop op);
    return (op == divop_div) || (op == divop_rem);
  endfunction

  // REM and REMU return the remainder instead of the quotient.
  function automatic logic divop_is_rem(rv32_divop op);
    return (op == divop_rem) || (op == divop_remu);
  endfunction

endpackage

// File: rtl/rv32_div_unit_step.sv
// One combinational restoring-division step on unsigned magnitudes.
// The {rem, quot} pair is shifted left by one; the divisor is trial
// subtracted from the widened partial remainder and the difference is
// kept only when it does not go negative, in which case the new quotient
// bit is 1.
module rv32_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quot_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quot_o
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] diff;

  // Shift, trial subtract, restore on borrow.
  always_comb begin
    rem_sh = {rem_i, quot_i[XLEN-1]};
    diff   = rem_sh - {1'b0, divisor_i};
    if (!diff[XLEN]) begin
      rem_o  = diff[XLEN-1:0];
      quot_o = {quot_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o  = rem_sh[XLEN-1:0];
      quot_o = {quot_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/rv32_div_unit.sv
// RV32M DIV/DIVU/REM/REMU iterative radix-2 restoring divider.
// UNROLL restoring steps (1 or 2) are resolved per clock. Operands are
// reduced to magnitudes at capture and the signs are re-applied in
// DIV_FIX. Divide-by-zero and signed overflow return the RISC-V defined
// values.
// Optional macro RV32_DIV_FAST_SPECIAL_EN: when defined, those special
// cases bypass the iteration and report done one cycle after start.
module rv32_div_unit
  import rv32_div_unit_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  rv32_divop       divop,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  rv32_register    rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output rv32_register    rd_out
);

  localparam int STEPS = XLEN / UNROLL;
  localparam int CNT_W = $clog2(STEPS + 1);
  // The package constant is 32 bits wide; this unit is an RV32 block.
  localparam logic [XLEN-1:0] ZERO_QUOT  = XLEN'(RV32_DIV_ZERO_QUOT);
  localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

  rv32_div_state   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] divisor_q, divisor_d;
  logic            quot_neg_q, quot_neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic            is_rem_q, is_rem_d;
  logic            special_q, special_d;
  logic [XLEN-1:0] special_res_q, special_res_d;
  logic [XLEN-1:0] result_q, result_d;
  rv32_register    rd_q, rd_d;

  // Operand decode of the incoming request.
  logic            in_signed, in_rem, a_neg, b_neg;
  logic            div_zero, sgn_ovf, in_special;
  logic [XLEN-1:0] a_mag, b_mag, special_val;

  // Classify the request and compute magnitudes and the special result.
  always_comb begin
    in_signed  = divop_is_signed(divop);
    in_rem     = divop_is_rem(divop);
    a_neg      = in_signed & op_a[XLEN-1];
    b_neg      = in_signed & op_b[XLEN-1];
    a_mag      = a_neg ? (~op_a + 1'b1) : op_a;
    b_mag      = b_neg ? (~op_b + 1'b1) : op_b;
    div_zero   = (op_b == '0);
    sgn_ovf    = in_signed && (op_a == SIGNED_MIN) && (op_b == '1);
    in_special = div_zero | sgn_ovf;
    if (div_zero) begin
      special_val = in_rem ? op_a : ZERO_QUOT;
    end else begin
      special_val = in_rem ? '0 : SIGNED_MIN;
    end
  end

  // Chain of UNROLL restoring steps fed from the working registers.
  logic [UNROLL:0][XLEN-1:0] chain_rem;
  logic [UNROLL:0][XLEN-1:0] chain_quot;

  assign chain_rem[0]  = rem_q;
  assign chain_quot[0] = quot_q;

  generate
    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
      rv32_div_step #(.XLEN(XLEN)) u_step (
        .rem_i     (chain_rem[gi]),
        .quot_i    (chain_quot[gi]),
        .divisor_i (divisor_q),
        .rem_o     (chain_rem[gi+1]),
        .quot_o    (chain_quot[gi+1])
      );
    end
  endgenerate

  // Sign-corrected result selected for the DIV_FIX cycle.
  logic [XLEN-1:0] quot_fix, rem_fix, fix_val;

  // Re-apply signs; special cases override the iterated value.
  always_comb begin
    quot_fix = quot_neg_q ? (~quot_q + 1'b1) : quot_q;
    rem_fix  = rem_neg_q ? (~rem_q + 1'b1) : rem_q;
    if (special_q) begin
      fix_val = special_res_q;
    end else begin
      fix_val = is_rem_q ? rem_fix : quot_fix;
    end
  end

  // Next-state and datapath update; flush always returns to idle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quot_d        = quot_q;
    divisor_d     = divisor_q;
    quot_neg_d    = quot_neg_q;
    rem_neg_d     = rem_neg_q;
    is_rem_d      = is_rem_q;
    special_d     = special_q;
    special_res_d = special_res_q;
    result_d      = result_q;
    rd_d          = rd_q;

    case (state_q)
      DIV_IDLE: begin
        if (start && !flush) begin
          cnt_d         = CNT_W'(STEPS);
          rem_d         = '0;
          quot_d        = a_mag;
          divisor_d     = b_mag;
          quot_neg_d    = a_neg ^ b_neg;
          rem_neg_d     = a_neg;
          is_rem_d      = in_rem;
          special_d     = in_special;
          special_res_d = special_val;
          rd_d          = rd_in;
`ifdef RV32_DIV_FAST_SPECIAL_EN
          if (in_special) begin
            result_d = special_val;
            state_d  = DIV_DONE;
          end else begin
            state_d  = DIV_CALC;
          end
`else
          state_d = DIV_CALC;
`endif
        end
      end
      DIV_CALC: begin
        rem_d  = chain_rem[UNROLL];
        quot_d = chain_quot[UNROLL];
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        result_d = fix_val;
        state_d  = DIV_DONE;
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase

    if (flush) begin
      state_d  = DIV_IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= DIV_IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quot_q        <= '0;
      divisor_q     <= '0;
      quot_neg_q    <= 1'b0;
      rem_neg_q     <= 1'b0;
      is_rem_q      <= 1'b0;
      special_q     <= 1'b0;
      special_res_q <= '0;
      result_q      <= '0;
      rd_q          <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quot_q        <= quot_d;
      divisor_q     <= divisor_d;
      quot_neg_q    <= quot_neg_d;
      rem_neg_q     <= rem_neg_d;
      is_rem_q      <= is_rem_d;
      special_q     <= special_d;
      special_res_q <= special_res_d;
      result_q      <= result_d;
      rd_q          <= rd_d;
    end
  end

  assign busy   = (state_q != DIV_IDLE);
  assign done   = (state_q == DIV_DONE) && !flush;
  assign result = result_q;
  assign rd_out = rd_q;

endmodule

// File: tb/tb_rv32_div_unit.sv
// Self-checking bench for rv32_div_unit. Two instances (UNROLL=1 and
// UNROLL=2) are exercised in turn with directed cases and random
// operations checked against a plain-arithmetic RISC-V reference model.
module tb_rv32_div_unit;
  import rv32_div_unit_pkg::*;

  localparam int NI = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]       rst_v, start_v, flush_v, busy_v, done_v;
  logic [NI-1:0][1:0]  divop_v;
  logic [NI-1:0][31:0] op_a_v, op_b_v, result_v;
  logic [NI-1:0][4:0]  rd_v, rd_out_v;

  int errors = 0;
  int checks = 0;

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      rv32_div_unit #(.XLEN(32), .UNROLL(gi + 1)) u_dut (
        .clk    (clk),
        .rst    (rst_v[gi]),
        .start  (start_v[gi]),
        .flush  (flush_v[gi]),
        .divop  (rv32_divop'(divop_v[gi])),
        .op_a   (op_a_v[gi]),
        .op_b   (op_b_v[gi]),
        .rd_in  (rd_v[gi]),
        .busy   (busy_v[gi]),
        .done   (done_v[gi]),
        .result (result_v[gi]),
        .rd_out (rd_out_v[gi])
      );
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V M-extension semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic   sgn;
    logic   want_rem;
    longint sa, sb, q, r;
    sgn      = (op == 2'd0) || (op == 2'd2);
    want_rem = (op == 2'd2) || (op == 2'd3);
    if (b == 32'd0) return want_rem ? a : 32'hFFFF_FFFF;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return want_rem ? r[31:0] : q[31:0];
  endfunction

  function automatic int exp_lat(input int u, input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    logic sgn;
    logic special;
    sgn     = (op == 2'd0) || (op == 2'd2);
    special = (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef RV32_DIV_FAST_SPECIAL_EN
    if (special) return 1;
`else
    if (special) return 32 / (u + 1) + 2;
`endif
    return 32 / (u + 1) + 2;
  endfunction

  // Present a request during the current cycle; returns in cycle 1.
  task automatic launch(input int u, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    start_v[u]  = 1'b1;
    divop_v[u]  = op;
    op_a_v[u]   = a;
    op_b_v[u]   = b;
    rd_v[u]     = rd;
    @(posedge clk); #1;
    start_v[u]  = 1'b0;
    op_a_v[u]   = $urandom;
    op_b_v[u]   = $urandom;
    rd_v[u]     = 5'($urandom_range(0, 31));
  endtask

  // Wait (bounded) for done starting from cycle n0; check latency and data,
  // then check the strobe drops in the following idle cycle.
  task automatic wait_done(input int u, input int n0, input int lat, input logic [31:0] res,
                           input logic [4:0] rd, input string tag);
    int n = n0;
    while (!done_v[u] && n < n0 + 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " result"}, result_v[u], res);
    check({tag, " rd_out"}, 32'(rd_out_v[u]), 32'(rd));
    $display("u%0d %s: result=%h rd=%0d done_cycle=%0d", u, tag, result_v[u], rd_out_v[u], n);
    @(posedge clk); #1;
    check({tag, " done_drop"}, 32'(done_v[u]), 32'd0);
    check({tag, " busy_drop"}, 32'(busy_v[u]), 32'd0);
  endtask

  task automatic run_op(input int u, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res,
                        input string tag);
    launch(u, op, a, b, rd);
    check({tag, " busy_c1"}, 32'(busy_v[u]), 32'd1);
    wait_done(u, 1, exp_lat(u, op, a, b), res, rd, tag);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] res;
  } vec_t;

  vec_t dirs[9];

  initial begin
    dirs[0] = '{2'd1, 32'd100, 32'd7, 5'd5, 32'd14};
    dirs[1] = '{2'd3, 32'd100, 32'd7, 5'd6, 32'd2};
    dirs[2] = '{2'd0, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFD};
    dirs[3] = '{2'd2, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'hFFFF_FFFF};
    dirs[4] = '{2'd2, 32'd7, 32'hFFFF_FFFE, 5'd9, 32'd1};
    dirs[5] = '{2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000};
    dirs[6] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0};
    dirs[7] = '{2'd1, 32'd5, 32'd0, 5'd12, 32'hFFFF_FFFF};
    dirs[8] = '{2'd2, 32'd5, 32'd0, 5'd13, 32'd5};

    rst_v   = '1;
    start_v = '0;
    flush_v = '0;
    divop_v = '0;
    op_a_v  = '0;
    op_b_v  = '0;
    rd_v    = '0;
    #1;
    for (int u = 0; u < NI; u++) begin
      check($sformatf("u%0d reset busy", u), 32'(busy_v[u]), 32'd0);
      check($sformatf("u%0d reset done", u), 32'(done_v[u]), 32'd0);
      check($sformatf("u%0d reset result", u), result_v[u], 32'd0);
      check($sformatf("u%0d reset rd_out", u), 32'(rd_out_v[u]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_v = '0;
    @(posedge clk); #1;

    for (int u = 0; u < NI; u++) begin
      int lat;
      int pulses;
      lat = 32 / (u + 1) + 2;

      // Directed cases from the RISC-V rules.
      for (int i = 0; i < 9; i++) begin
        run_op(u, dirs[i].op, dirs[i].a, dirs[i].b, dirs[i].rd, dirs[i].res,
               $sformatf("dir%0d", i));
      end

      // Start while busy is ignored; back-to-back issue after done.
      launch(u, 2'd1, 32'd50, 32'd5, 5'd3);
      repeat (9) begin @(posedge clk); #1; end
      start_v[u] = 1'b1;
      divop_v[u] = 2'd1;
      op_a_v[u]  = 32'd9;
      op_b_v[u]  = 32'd3;
      rd_v[u]    = 5'd9;
      @(posedge clk); #1;
      start_v[u] = 1'b0;
      wait_done(u, 11, lat, 32'd10, 5'd3, "ignore");
      run_op(u, 2'd1, 32'd9, 32'd3, 5'd9, 32'd3, "b2b");

      // Flush in cycle 15 aborts without a done pulse.
      launch(u, 2'd1, 32'd1000, 32'd3, 5'd1);
      repeat (14) begin @(posedge clk); #1; end
      flush_v[u] = 1'b1;
      @(posedge clk); #1;
      flush_v[u] = 1'b0;
      check("flush busy", 32'(busy_v[u]), 32'd0);
      pulses = 0;
      repeat (40) begin
        if (done_v[u]) pulses++;
        @(posedge clk); #1;
      end
      check("flush no_done", 32'(pulses), 32'd0);

      // Start coincident with flush launches nothing.
      start_v[u] = 1'b1;
      flush_v[u] = 1'b1;
      divop_v[u] = 2'd1;
      op_a_v[u]  = 32'd20;
      op_b_v[u]  = 32'd4;
      @(posedge clk); #1;
      start_v[u] = 1'b0;
      flush_v[u] = 1'b0;
      check("startflush busy", 32'(busy_v[u]), 32'd0);
      pulses = 0;
      repeat (40) begin
        if (done_v[u]) pulses++;
        @(posedge clk); #1;
      end
      check("startflush no_done", 32'(pulses), 32'd0);

      // Asynchronous reset mid-iteration, then a clean operation.
      run_op(u, 2'd1, 32'd1000, 32'd3, 5'd17, 32'd333, "pre_rst");
      launch(u, 2'd1, 32'd77, 32'd7, 5'd12);
      repeat (5) begin @(posedge clk); #1; end
      #2;
      rst_v[u] = 1'b1;
      #1;
      check("arst busy", 32'(busy_v[u]), 32'd0);
      check("arst done", 32'(done_v[u]), 32'd0);
      check("arst result", result_v[u], 32'd0);
      check("arst rd_out", 32'(rd_out_v[u]), 32'd0);
      @(posedge clk); #1;
      rst_v[u] = 1'b0;
      @(posedge clk); #1;
      run_op(u, 2'd1, 32'd77, 32'd7, 5'd12, 32'd11, "post_rst");

      // Random operations against the reference model.
      for (int i = 0; i < 30; i++) begin
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;
        op = 2'($urandom_range(0, 3));
        a  = $urandom;
        rd = 5'($urandom_range(0, 31));
        case ($urandom_range(0, 7))
          0: b = 32'd0;
          1: b = 32'($urandom_range(1, 15));
          2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
          3: b = $urandom >> $urandom_range(0, 31);
          default: b = $urandom;
        endcase
        run_op(u, op, a, b, rd, model(op, a, b), $sformatf("rnd%0d op%0d", i, op));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
